led_pattern_gen: RTL and testbench

//  Parametrised multi-channel LED pattern generator; successor of the 2-LED state-driven blinker.

---
 rtl/led_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: blink/alternate/chase/bounce/fill patterns
// advanced on a prescaled low-frequency tick, restarting cleanly on any mode change.
module led_pattern_gen #(
  parameter int N_LEDS = 8,
  parameter int DIV    = 1,
  parameter int SEL_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              tick_lf,
  output logic [N_LEDS-1:0] leds,
  output logic              step_pulse
);
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FILL_W = $clog2(N_LEDS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [SEL_W-1:0]  POS_LAST = SEL_W'(N_LEDS - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N_LEDS);
  localparam logic [N_LEDS-1:0] ONE      = N_LEDS'(1);

  localparam logic [2:0] M_BLINK_SEL = 3'd1;
  localparam logic [2:0] M_BLINK_ALL = 3'd2;
  localparam logic [2:0] M_ALT       = 3'd3;
  localparam logic [2:0] M_CHASE     = 3'd4;
  localparam logic [2:0] M_BOUNCE    = 3'd5;
  localparam logic [2:0] M_FILL      = 3'd6;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [2:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [SEL_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              step_pulse_q, step_pulse_d;
  logic              step_s, restart_s, active_s;

  function automatic logic is_active(input logic [2:0] m);
    case (m)
      M_BLINK_SEL, M_BLINK_ALL, M_ALT, M_CHASE, M_BOUNCE, M_FILL: is_active = 1'b1;
      default:                                                    is_active = 1'b0;
    endcase
  endfunction

  assign mode_d    = mode;
  assign restart_s = (mode != mode_q);
  assign active_s  = is_active(mode);

  // Prescaler and pattern state; a mode change zeroes everything and swallows that cycle's step
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    step_s  = 1'b0;
    if (restart_s) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      pos_d   = '0;
      dir_d   = DIR_UP;
      fill_d  = '0;
    end else if (active_s && tick_lf) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      step_s = 1'b0;
    end

    if (step_s) begin
      case (mode)
        M_BLINK_SEL, M_BLINK_ALL, M_ALT: phase_d = ~phase_q;
        M_CHASE: begin
          if (pos_q == POS_LAST) pos_d = '0;
          else                   pos_d = pos_q + SEL_W'(1);
        end
        M_BOUNCE: begin
          // Direction flips on the end position so each end is shown only once
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              dir_d = DIR_DOWN;
              pos_d = (N_LEDS > 1) ? pos_q - SEL_W'(1) : pos_q;
            end else begin
              pos_d = pos_q + SEL_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = (N_LEDS > 1) ? pos_q + SEL_W'(1) : pos_q;
            end else begin
              pos_d = pos_q - SEL_W'(1);
            end
          end
        end
        M_FILL: begin
          if (fill_q == FILL_MAX) fill_d = '0;
          else                    fill_d = fill_q + FILL_W'(1);
        end
        default: phase_d = phase_q;
      endcase
    end else begin
      fill_d = fill_d;
    end
  end

  assign step_pulse_d = step_s;

  // LED image of the next state, so leds track state with the same one-cycle latency
  always_comb begin
    leds_d = '0;
    case (mode)
      M_BLINK_SEL: begin
        if (phase_d && ({1'b0, sel} < (SEL_W + 1)'(N_LEDS))) leds_d = ONE << sel;
        else                                                   leds_d = '0;
      end
      M_BLINK_ALL: leds_d = {N_LEDS{phase_d}};
      M_ALT: begin
        for (int i = 0; i < N_LEDS; i++) leds_d[i] = ((i % 2) == 0) ? phase_d : ~phase_d;
      end
      M_CHASE, M_BOUNCE: leds_d = ONE << pos_d;
      M_FILL: begin
        for (int i = 0; i < N_LEDS; i++) leds_d[i] = (FILL_W'(i) < fill_d);
      end
      default: leds_d = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= mode;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      pos_q        <= '0;
      dir_q        <= DIR_UP;
      fill_q       <= '0;
      leds_q       <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      fill_q       <= fill_d;
      leds_q       <= leds_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: four instances (N=8/DIV=1, N=4, N=8/DIV=3, N=5)
// share one stimulus stream; expected outputs are queued per driven cycle.
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [2:0] sel = 3'd0;
  logic       tick = 1'b0;

  logic [7:0] leds_a;
  logic       pulse_a;
  logic [3:0] leds_b;
  logic       pulse_b;
  logic [7:0] leds_c;
  logic       pulse_c;
  logic [4:0] leds_d;
  logic       pulse_d;

  typedef struct {
    string      tag;
    logic [3:0] en;
    logic [7:0] a;
    logic       p;
    logic [3:0] b;
    logic [7:0] c;
    logic       pc;
    logic [4:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] a_bounce [8];
  logic [3:0] b_bounce [8];
  logic [4:0] d_bounce [8];

  always #5 clk = ~clk;

  led_pattern_gen #(.N_LEDS(8), .DIV(1)) u_a (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .tick_lf(tick),
    .leds(leds_a), .step_pulse(pulse_a));
  led_pattern_gen #(.N_LEDS(4), .DIV(1)) u_b (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel[1:0]), .tick_lf(tick),
    .leds(leds_b), .step_pulse(pulse_b));
  led_pattern_gen #(.N_LEDS(8), .DIV(3)) u_c (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .tick_lf(tick),
    .leds(leds_c), .step_pulse(pulse_c));
  led_pattern_gen #(.N_LEDS(5), .DIV(1)) u_d (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .tick_lf(tick),
    .leds(leds_d), .step_pulse(pulse_d));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after the next edge
  task automatic drive(input string tag, input logic r, input logic [2:0] m, input logic [2:0] s,
                       input logic t, input logic [3:0] en, input logic [7:0] ea, input logic ep,
                       input logic [3:0] eb, input logic [7:0] ec, input logic epc,
                       input logic [4:0] ed);
    exp_t e;
    @(negedge clk);
    rst  = r;
    mode = m;
    sel  = s;
    tick = t;
    e.tag = tag; e.en = en; e.a = ea; e.p = ep; e.b = eb; e.c = ec; e.pc = epc; e.d = ed;
    sb_q.push_back(e);
  endtask

  // Monitor: compare one queued expectation just after each active edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.en[0]) begin
        check_eq({e.tag, ".leds_a"}, 32'(leds_a), 32'(e.a));
        check_eq({e.tag, ".pulse_a"}, 32'(pulse_a), 32'(e.p));
      end
      if (e.en[1]) begin
        check_eq({e.tag, ".leds_b"}, 32'(leds_b), 32'(e.b));
        check_eq({e.tag, ".pulse_b"}, 32'(pulse_b), 32'(e.p));
      end
      if (e.en[2]) begin
        check_eq({e.tag, ".leds_c"}, 32'(leds_c), 32'(e.c));
        check_eq({e.tag, ".pulse_c"}, 32'(pulse_c), 32'(e.pc));
      end
      if (e.en[3]) begin
        check_eq({e.tag, ".leds_d"}, 32'(leds_d), 32'(e.d));
        check_eq({e.tag, ".pulse_d"}, 32'(pulse_d), 32'(e.p));
      end
    end
  end

  initial begin
    a_bounce = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    b_bounce = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
    d_bounce = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01};

    drive("reset", 1'b1, 3'd0, 3'd0, 1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);

    // Chase: every tick steps the DIV=1 instances; DIV=3 steps every third tick
    drive("chase_start", 1'b0, 3'd4, 3'd0, 1'b0, 4'hF, 8'h01, 1'b0, 4'h1, 8'h01, 1'b0, 5'h01);
    for (int k = 1; k <= 13; k++) begin
      drive("chase_tick", 1'b0, 3'd4, 3'd0, 1'b1, 4'hF, 8'(32'd1 << (k % 8)), 1'b1,
            4'(32'd1 << (k % 4)), 8'(32'd1 << ((k / 3) % 8)), ((k % 3) == 0), 5'(32'd1 << (k % 5)));
      drive("chase_idle", 1'b0, 3'd4, 3'd0, 1'b0, 4'hF, 8'(32'd1 << (k % 8)), 1'b0,
            4'(32'd1 << (k % 4)), 8'(32'd1 << ((k / 3) % 8)), 1'b0, 5'(32'd1 << (k % 5)));
    end

    // Reset in the middle of a chase, then the chase resumes from LED0
    drive("mid_reset", 1'b1, 3'd4, 3'd0, 1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("post_reset", 1'b0, 3'd4, 3'd0, 1'b0, 4'hF, 8'h01, 1'b0, 4'h1, 8'h01, 1'b0, 5'h01);
    drive("post_reset_tick", 1'b0, 3'd4, 3'd0, 1'b1, 4'hF, 8'h02, 1'b1, 4'h2, 8'h01, 1'b0, 5'h02);

    // Bounce: ends shown once
    drive("bounce_start", 1'b0, 3'd5, 3'd0, 1'b0, 4'hF, 8'h01, 1'b0, 4'h1, 8'h01, 1'b0, 5'h01);
    for (int k = 1; k <= 8; k++) begin
      drive("bounce_tick", 1'b0, 3'd5, 3'd0, 1'b1, 4'hF, a_bounce[k-1], 1'b1, b_bounce[k-1],
            8'(32'd1 << (k / 3)), ((k % 3) == 0), d_bounce[k-1]);
      drive("bounce_idle", 1'b0, 3'd5, 3'd0, 1'b0, 4'hF, a_bounce[k-1], 1'b0, b_bounce[k-1],
            8'(32'd1 << (k / 3)), 1'b0, d_bounce[k-1]);
    end

    // Blink-all: the DIV=3 instance toggles only after ticks 3 and 6
    drive("blink_all_start", 1'b0, 3'd2, 3'd0, 1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    for (int k = 1; k <= 6; k++) begin
      drive("blink_all_tick", 1'b0, 3'd2, 3'd0, 1'b1, 4'hF, ((k % 2) == 1) ? 8'hFF : 8'h00, 1'b1,
            ((k % 2) == 1) ? 4'hF : 4'h0, (k >= 3 && k < 6) ? 8'hFF : 8'h00, ((k % 3) == 0),
            ((k % 2) == 1) ? 5'h1F : 5'h00);
      drive("blink_all_idle", 1'b0, 3'd2, 3'd0, 1'b0, 4'hF, ((k % 2) == 1) ? 8'hFF : 8'h00, 1'b0,
            ((k % 2) == 1) ? 4'hF : 4'h0, (k >= 3 && k < 6) ? 8'hFF : 8'h00, 1'b0,
            ((k % 2) == 1) ? 5'h1F : 5'h00);
    end

    // Blink-select: sel changes apply next edge; out-of-range sel on the 5-LED instance is dark
    drive("bsel_start", 1'b0, 3'd1, 3'd2, 1'b0, 4'h9, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("bsel_t1", 1'b0, 3'd1, 3'd2, 1'b1, 4'h9, 8'h04, 1'b1, 4'h0, 8'h00, 1'b0, 5'h04);
    drive("bsel_idle", 1'b0, 3'd1, 3'd2, 1'b0, 4'h9, 8'h04, 1'b0, 4'h0, 8'h00, 1'b0, 5'h04);
    drive("bsel_t2", 1'b0, 3'd1, 3'd2, 1'b1, 4'h9, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("bsel_t3", 1'b0, 3'd1, 3'd2, 1'b1, 4'h9, 8'h04, 1'b1, 4'h0, 8'h00, 1'b0, 5'h04);
    drive("bsel_sel7", 1'b0, 3'd1, 3'd7, 1'b0, 4'h9, 8'h80, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("bsel_sel7_t", 1'b0, 3'd1, 3'd7, 1'b1, 4'h9, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("bsel_sel7_t2", 1'b0, 3'd1, 3'd7, 1'b1, 4'h9, 8'h80, 1'b1, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("bsel_back", 1'b0, 3'd1, 3'd2, 1'b0, 4'h9, 8'h04, 1'b0, 4'h0, 8'h00, 1'b0, 5'h04);

    // Mode change on the same edge as a step: restart wins, prescaler not advanced
    drive("pre_fill", 1'b0, 3'd4, 3'd0, 1'b0, 4'hF, 8'h01, 1'b0, 4'h1, 8'h01, 1'b0, 5'h01);
    drive("pre_fill_t", 1'b0, 3'd4, 3'd0, 1'b1, 4'hF, 8'h02, 1'b1, 4'h2, 8'h01, 1'b0, 5'h02);
    drive("fill_switch", 1'b0, 3'd6, 3'd0, 1'b1, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("fill_hold", 1'b0, 3'd6, 3'd0, 1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    for (int k = 1; k <= 5; k++) begin
      drive("fill_tick", 1'b0, 3'd6, 3'd0, 1'b1, 4'hF, 8'((32'd1 << k) - 32'd1), 1'b1,
            (k == 5) ? 4'h0 : 4'((32'd1 << k) - 32'd1), (k >= 3) ? 8'h01 : 8'h00, (k == 3),
            5'((32'd1 << k) - 32'd1));
      drive("fill_idle", 1'b0, 3'd6, 3'd0, 1'b0, 4'hF, 8'((32'd1 << k) - 32'd1), 1'b0,
            (k == 5) ? 4'h0 : 4'((32'd1 << k) - 32'd1), (k >= 3) ? 8'h01 : 8'h00, 1'b0,
            5'((32'd1 << k) - 32'd1));
    end

    // Alternate pattern, then mode 7 and OFF stay dark with no step pulses
    drive("alt_start", 1'b0, 3'd3, 3'd0, 1'b0, 4'hF, 8'hAA, 1'b0, 4'hA, 8'hAA, 1'b0, 5'h0A);
    drive("alt_tick", 1'b0, 3'd3, 3'd0, 1'b1, 4'hF, 8'h55, 1'b1, 4'h5, 8'hAA, 1'b0, 5'h15);
    drive("alt_idle", 1'b0, 3'd3, 3'd0, 1'b0, 4'hF, 8'h55, 1'b0, 4'h5, 8'hAA, 1'b0, 5'h15);
    drive("mode7", 1'b0, 3'd7, 3'd0, 1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("mode7_tick", 1'b0, 3'd7, 3'd0, 1'b1, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("off", 1'b0, 3'd0, 3'd0, 1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("off_tick", 1'b0, 3'd0, 3'd0, 1'b1, 4'hF, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 5'h00);
    drive("chase_again", 1'b0, 3'd4, 3'd0, 1'b0, 4'hF, 8'h01, 1'b0, 4'h1, 8'h01, 1'b0, 5'h01);
    drive("chase_again_t", 1'b0, 3'd4, 3'd0, 1'b1, 4'hF, 8'h02, 1'b1, 4'h2, 8'h01, 1'b0, 5'h02);
    drive("final_idle", 1'b0, 3'd4, 3'd0, 1'b0, 4'hF, 8'h02, 1'b0, 4'h2, 8'h01, 1'b0, 5'h02);

    repeat (3) @(posedge clk);
    #2;
    check_eq("drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
